pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
- Multi-channel PWM scheduler built around one shared free-running up-counter.
- Holds per-channel duty and a common period. Configuration arrives over a valid/ready write port into shadow registers.
- Shadow values commit to active registers only at a period boundary, so the output never glitches.
- Sits between the register/config master and the PWM pins. Sequences start, run and a clean stop.

Parameters:
- CNT_W, 4, counter / duty / period width in bits.
- N_CH, 4, number of PWM channels (1..8).
- PRESCALE, 1, clk cycles per counter step (1..256); 1 = step every clk.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready.
- cfg_addr  in  4  0..N_CH-1 = duty of channel addr; N_CH = period top; others = invalid.
- cfg_data  in  CNT_W  write data.
- cfg_err  out  1  one-cycle pulse: accepted write to an invalid address.
- pwm_out  out  N_CH  PWM outputs, registered.
- cnt  out  CNT_W  current counter value.
- period_tick  out  1  one-cycle pulse on the counter wrap step.
- busy  out  1  high in RUN or STOP.

Behaviour:
- Reset (clk edge with reset=1) sets:
  - state=IDLE; cnt=0; prescaler=0.
  - All duty shadow/active = 0; top shadow/active = all ones.
  - pwm_out=0, cfg_err=0, period_tick=0, busy=0, cfg_ready=1.
- Reset overrides every other input in the same cycle, including mid-period and mid-write. A write presented with reset=1 is dropped.
- step = (prescaler == PRESCALE-1); the prescaler counts 0..PRESCALE-1 and wraps. It is held at 0 in IDLE.
- wrap = step && (cnt == top_act). On step: cnt <= wrap ? 0 : cnt+1.
- top_act = 0 is legal: cnt stays 0 and wrap occurs on every step.
- States:
  - IDLE: cnt held 0, pwm_out=0. en=1 -> RUN next cycle; cnt starts at 0 with prescaler 0.
  - RUN: counting. en=0 sampled -> STOP.
  - STOP: keeps counting to the end of the current period. On wrap -> IDLE. If en is reasserted before the wrap -> back to RUN, no gap.
- PWM compare: in every cycle, pwm_out[i] == (state != IDLE) && (cnt < duty_act[i]), aligned with cnt in the same cycle. pwm_out is a register computed from next-state values.
  - duty = 0 gives always low.
  - duty > top_act gives always high.
  - Comparison is unsigned, CNT_W bits.
- Config writes:
  - IDLE: the accepted write updates both shadow and active registers; effective the next cycle.
  - RUN/STOP: the write updates the shadow only.
  - All shadows copy to active on the cycle of wrap. The new values apply from cnt=0 of the next period.
- cfg_ready = 0 only in the cycle where wrap=1 in RUN/STOP, so there is no write/commit race. It is 1 otherwise.
- Multiple writes to the same address before a commit: last one wins.
- Invalid cfg_addr: write accepted (handshake completes), no register changes, cfg_err=1 the next cycle for one cycle.
- period_tick: registered, asserted the cycle after wrap, one cycle wide. Never asserted in IDLE except the tick from the final STOP wrap.
- busy = (state != IDLE).

Decomposition:
- Shared package pwm_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2.
  - default CNT_W.
  - cfg address constant ADDR_TOP = N_CH.
- One natural sub-module: pwm_prescaler (tick generator: counter 0..PRESCALE-1, enable input, synchronous clear, step output).
- Counter, shadow/active register file, FSM and compare stay in pwm_ctrl.

Test Plan:
- Basic duty: reset, write top=7 and duty0=3 in IDLE, en=1 -> cnt cycles 0..7; pwm_out[0] high for exactly 3 of every 8 clks (cnt 0,1,2); period_tick pulses every 8 clks.
- Shadow commit: in RUN with top=7 and duty0=3, write duty0=6 at cnt=2 -> the current period still shows 3 high cycles; the next period shows 6. cfg_ready is low only on the cnt=7 step cycle.
- Extremes: duty1=0 gives pwm_out[1] always 0; duty2=15 with top=7 gives always 1. top=0 gives cnt stuck at 0, period_tick every clk, duty=1 gives constant high.
- Prescale (PRESCALE=3, top=3, duty0=2): each cnt value is held 3 clks; pwm_out[0] high 6 of every 12 clks.
- Stop/restart: drop en at cnt=4 (top=7) -> counting continues to 7, then IDLE with pwm_out=0 and busy=0. Reassert en at cnt=5 instead -> no interruption.
- Reset and error: assert reset mid-period at cnt=5 -> the next cycle has cnt=0, pwm_out=0, state IDLE, top=15. A write to addr=9 gives cfg_err as a one-cycle pulse and no register change.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM scheduler.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } pwm_state_e;

   localparam int unsigned DEF_CNT_W = 4;
   localparam int unsigned DEF_N_CH  = 4;

   // Config address of the period-top register; duty addresses occupy 0..n_ch-1.
   function automatic logic [3:0] addr_top(input int unsigned n_ch);
      return 4'(n_ch);
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step generator: counts 0..PRESCALE-1 while enabled and flags the last count.
module pwm_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_step
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] r_cnt;
   logic          w_at_max;

   assign w_at_max = (r_cnt == MAX);
   assign o_step   = i_en && !i_clr && w_at_max;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_at_max ? '0 : r_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/pwm_ctrl.sv
// Multi-channel PWM with a shared up-counter; shadowed config commits on the period wrap.
module pwm_ctrl
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned N_CH     = DEF_N_CH,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [3:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_data,
   output logic             cfg_err,
   output logic [N_CH-1:0]  pwm_out,
   output logic [CNT_W-1:0] cnt,
   output logic             period_tick,
   output logic             busy
);

   localparam logic [3:0] ADDR_TOP = addr_top(N_CH);

   pwm_state_e                  r_state;
   pwm_state_e                  w_state_d;
   logic [CNT_W-1:0]            r_cnt;
   logic [CNT_W-1:0]            w_cnt_d;
   logic [N_CH-1:0][CNT_W-1:0]  r_duty_sh;
   logic [N_CH-1:0][CNT_W-1:0]  r_duty_act;
   logic [N_CH-1:0][CNT_W-1:0]  w_duty_sh_d;
   logic [N_CH-1:0][CNT_W-1:0]  w_duty_act_d;
   logic [CNT_W-1:0]            r_top_sh;
   logic [CNT_W-1:0]            r_top_act;
   logic [CNT_W-1:0]            w_top_sh_d;
   logic [CNT_W-1:0]            w_top_act_d;
   logic [N_CH-1:0]             r_pwm;
   logic [N_CH-1:0]             w_pwm_d;
   logic                        r_cfg_err;
   logic                        r_tick;
   logic                        w_idle;
   logic                        w_step;
   logic                        w_wrap;
   logic                        w_accept;
   logic                        w_addr_duty;
   logic                        w_addr_top;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_wrap      = w_step && (r_cnt == r_top_act);
   // Block writes on the commit cycle so a write can never race the shadow copy.
   assign cfg_ready   = !w_wrap;
   assign w_accept    = cfg_valid && cfg_ready;
   assign w_addr_duty = (cfg_addr < ADDR_TOP);
   assign w_addr_top  = (cfg_addr == ADDR_TOP);

   pwm_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .i_clk  (clk),
      .i_reset(reset),
      .i_en   (!w_idle),
      .i_clr  (w_idle),
      .o_step (w_step)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         ST_IDLE: if (en) w_state_d = ST_RUN;
         ST_RUN:  if (!en) w_state_d = ST_STOP;
         ST_STOP: begin
            if (en) begin
               w_state_d = ST_RUN;
            end else if (w_wrap) begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_d = r_cnt;
      if (w_idle || w_wrap) begin
         w_cnt_d = '0;
      end else if (w_step) begin
         w_cnt_d = r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_duty_sh_d  = r_duty_sh;
      w_duty_act_d = r_duty_act;
      w_top_sh_d   = r_top_sh;
      w_top_act_d  = r_top_act;
      if (w_wrap) begin
         w_duty_act_d = r_duty_sh;
         w_top_act_d  = r_top_sh;
      end
      if (w_accept) begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_addr_duty && (cfg_addr == 4'(i))) begin
               w_duty_sh_d[i] = cfg_data;
               if (w_idle) begin
                  w_duty_act_d[i] = cfg_data;
               end
            end
         end
         if (w_addr_top) begin
            w_top_sh_d = cfg_data;
            if (w_idle) begin
               w_top_act_d = cfg_data;
            end
         end
      end
   end

   // Compare against next-state values so the registered output lines up with cnt.
   always_comb begin
      w_pwm_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_pwm_d[i] = (w_state_d != ST_IDLE) && (w_cnt_d < w_duty_act_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_duty_sh  <= '0;
         r_duty_act <= '0;
         r_top_sh   <= '1;
         r_top_act  <= '1;
         r_pwm      <= '0;
         r_cfg_err  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_duty_sh  <= w_duty_sh_d;
         r_duty_act <= w_duty_act_d;
         r_top_sh   <= w_top_sh_d;
         r_top_act  <= w_top_act_d;
         r_pwm      <= w_pwm_d;
         r_cfg_err  <= w_accept && !w_addr_duty && !w_addr_top;
         r_tick     <= w_wrap;
      end
   end

   assign pwm_out     = r_pwm;
   assign cnt         = r_cnt;
   assign cfg_err     = r_cfg_err;
   assign period_tick = r_tick;
   assign busy        = !w_idle;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed self-checking bench for pwm_ctrl (PRESCALE=1 and PRESCALE=3 instances).
module tb_pwm_ctrl;

   logic       clk;
   logic       reset, en, cfg_valid;
   logic [3:0] cfg_addr, cfg_data;
   logic       cfg_ready, cfg_err, period_tick, busy;
   logic [3:0] pwm_out, cnt;

   logic       p_reset, p_en, p_cfg_valid;
   logic [3:0] p_cfg_addr, p_cfg_data;
   logic       p_cfg_ready, p_cfg_err, p_period_tick, p_busy;
   logic [3:0] p_pwm_out, p_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pwm_ctrl #(.CNT_W(4), .N_CH(4), .PRESCALE(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_err    (cfg_err),
      .pwm_out    (pwm_out),
      .cnt        (cnt),
      .period_tick(period_tick),
      .busy       (busy)
   );

   pwm_ctrl #(.CNT_W(4), .N_CH(4), .PRESCALE(3)) dut3 (
      .clk        (clk),
      .reset      (p_reset),
      .en         (p_en),
      .cfg_valid  (p_cfg_valid),
      .cfg_ready  (p_cfg_ready),
      .cfg_addr   (p_cfg_addr),
      .cfg_data   (p_cfg_data),
      .cfg_err    (p_cfg_err),
      .pwm_out    (p_pwm_out),
      .cnt        (p_cnt),
      .period_tick(p_period_tick),
      .busy       (p_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_cfg(input logic [3:0] a, input logic [3:0] d);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_idle", 32'(busy), 0);
   endtask

   initial begin
      logic [3:0] exp_pwm;
      int c;
      int d0;

      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      p_reset = 1'b1; p_en = 1'b0; p_cfg_valid = 1'b0; p_cfg_addr = '0; p_cfg_data = '0;
      repeat (3) @(negedge clk);

      check_eq("rst_cnt", 32'(cnt), 0);
      check_eq("rst_pwm", 32'(pwm_out), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_ready", 32'(cfg_ready), 1);
      check_eq("rst_tick", 32'(period_tick), 0);
      check_eq("rst_err", 32'(cfg_err), 0);
      reset = 1'b0;

      // top=7, duty = {5, 15, 0, 3}
      write_cfg(4'd4, 4'd7);
      write_cfg(4'd0, 4'd3);
      write_cfg(4'd1, 4'd0);
      write_cfg(4'd2, 4'd15);
      write_cfg(4'd3, 4'd5);
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         c = k % 8;
         exp_pwm = {(c < 5), 1'b1, 1'b0, (c < 3)};
         check_eq("basic_cnt", 32'(cnt), 32'(c));
         check_eq("basic_pwm", 32'(pwm_out), 32'(exp_pwm));
         check_eq("basic_tick", 32'(period_tick), 32'(k > 0 && c == 0));
         check_eq("basic_busy", 32'(busy), 1);
         @(negedge clk);
      end

      // Shadow write of duty0=6 at cnt=2 takes effect only next period.
      repeat (2) @(negedge clk);
      cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd6;
      for (int k = 2; k < 16; k++) begin
         c  = k % 8;
         d0 = (k < 8) ? 3 : 6;
         check_eq("shadow_cnt", 32'(cnt), 32'(c));
         check_eq("shadow_pwm0", 32'(pwm_out[0]), 32'(c < d0));
         check_eq("shadow_ready", 32'(cfg_ready), 32'(c != 7));
         @(negedge clk);
         cfg_valid = 1'b0;
      end

      // Drop en at cnt=4: finishes the period, then idle.
      repeat (4) @(negedge clk);
      check_eq("stop_at4", 32'(cnt), 4);
      en = 1'b0;
      for (int k = 5; k < 8; k++) begin
         @(negedge clk);
         check_eq("stop_cnt", 32'(cnt), 32'(k));
         check_eq("stop_busy", 32'(busy), 1);
         check_eq("stop_pwm0", 32'(pwm_out[0]), 32'(k < 6));
      end
      @(negedge clk);
      check_eq("stop_idle_cnt", 32'(cnt), 0);
      check_eq("stop_idle_busy", 32'(busy), 0);
      check_eq("stop_idle_pwm", 32'(pwm_out), 0);
      check_eq("stop_final_tick", 32'(period_tick), 1);
      @(negedge clk);
      check_eq("idle_tick", 32'(period_tick), 0);
      check_eq("idle_cnt", 32'(cnt), 0);

      // Restart, drop en at cnt=4 and reassert at cnt=5: no gap.
      en = 1'b1;
      @(negedge clk);
      check_eq("restart_cnt", 32'(cnt), 0);
      repeat (4) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check_eq("reassert_cnt5", 32'(cnt), 5);
      en = 1'b1;
      for (int k = 6; k < 10; k++) begin
         @(negedge clk);
         c = k % 8;
         check_eq("reassert_cnt", 32'(cnt), 32'(c));
         check_eq("reassert_busy", 32'(busy), 1);
         check_eq("reassert_tick", 32'(period_tick), 32'(c == 0));
      end

      // top=0, duty0=1: cnt pinned at 0, tick every clk.
      en = 1'b0;
      wait_idle(20);
      write_cfg(4'd4, 4'd0);
      write_cfg(4'd0, 4'd1);
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         check_eq("top0_cnt", 32'(cnt), 0);
         check_eq("top0_tick", 32'(period_tick), 32'(k > 0));
         check_eq("top0_pwm", 32'(pwm_out), 32'h0000_000d);
         check_eq("top0_ready", 32'(cfg_ready), 0);
         @(negedge clk);
      end

      // Reset mid-period at cnt=5 with a write presented: write dropped, top back to 15.
      en = 1'b0;
      wait_idle(20);
      write_cfg(4'd4, 4'd7);
      en = 1'b1;
      @(negedge clk);
      repeat (5) @(negedge clk);
      check_eq("pre_rst_cnt", 32'(cnt), 5);
      reset = 1'b1;
      cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd9;
      @(negedge clk);
      check_eq("mid_rst_cnt", 32'(cnt), 0);
      check_eq("mid_rst_pwm", 32'(pwm_out), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      reset = 1'b0; cfg_valid = 1'b0; en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 17; k++) begin
         check_eq("post_rst_cnt", 32'(cnt), 32'(k % 16));
         check_eq("post_rst_pwm", 32'(pwm_out), 0);
         check_eq("post_rst_tick", 32'(period_tick), 32'(k == 16));
         @(negedge clk);
      end

      // Invalid address: handshake completes, one-cycle error, nothing changes.
      en = 1'b0;
      wait_idle(40);
      write_cfg(4'd9, 4'd3);
      check_eq("err_pulse", 32'(cfg_err), 1);
      @(negedge clk);
      check_eq("err_clear", 32'(cfg_err), 0);
      en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 11; k++) begin
         check_eq("err_cnt", 32'(cnt), 32'(k));
         check_eq("err_pwm", 32'(pwm_out), 0);
         @(negedge clk);
      end
      en = 1'b0;

      // PRESCALE=3, top=3, duty0=2.
      p_reset = 1'b0;
      @(negedge clk);
      p_cfg_valid = 1'b1; p_cfg_addr = 4'd4; p_cfg_data = 4'd3;
      @(negedge clk);
      p_cfg_addr = 4'd0; p_cfg_data = 4'd2;
      @(negedge clk);
      p_cfg_valid = 1'b0;
      p_en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 25; k++) begin
         c = (k / 3) % 4;
         check_eq("pre_cnt", 32'(p_cnt), 32'(c));
         check_eq("pre_pwm0", 32'(p_pwm_out[0]), 32'(c < 2));
         check_eq("pre_tick", 32'(p_period_tick), 32'(k > 0 && (k % 12) == 0));
         @(negedge clk);
      end
      p_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
